id_ex_stage: RTL and testbench

Decode-to-execute pipeline register for the 64-bit integer pipeline; it sits directly upstream of `alu_64_bit`. Each cycle it accepts one decoded instruction, maps it to the ALU's 4-bit opcode, and selects and forwards both operands. It detects load-use hazards and registers everything the execute stage consumes: `a`, `b`, `opcode`, store data and writeback control. The register file is write-through, so forwarding covers only the EX and EX/MEM sources.

---
 rtl/id_ex_stage.sv | 186 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage
// Decode-to-execute pipeline register for the 64-bit integer pipeline.
// Maps each decoded instruction to the ALU's 4-bit opcode, forwards both
// source operands from EX and EX/MEM, detects load-use hazards and
// registers everything the execute stage consumes.
//
// Ports
//   clk, reset         : clock; synchronous active-high reset
//   id_*               : decoded instruction in the ID slot
//   ex_alu_result      : ALU result of the instruction currently in EX
//   exmem_*            : destination / value of the instruction in EX/MEM
//   stall, flush       : downstream hold; kill of the ID instruction
//   hazard_stall       : combinational load-use hold request to upstream
//   ex_*               : registered execute-stage controls and operands
module id_ex_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [2:0]      id_class,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic            id_reg_write,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_reg_write,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            stall,
  input  logic            flush,
  output logic            hazard_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_opcode,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic [2:0]      ex_class,
  output logic [2:0]      ex_funct3
);

  localparam logic [2:0] CLS_R     = 3'd0;
  localparam logic [2:0] CLS_I     = 3'd1;
  localparam logic [2:0] CLS_LOAD  = 3'd2;
  localparam logic [2:0] CLS_STORE = 3'd3;
  localparam logic [2:0] CLS_BR    = 3'd4;
  localparam logic [2:0] CLS_LUI   = 3'd5;
  localparam logic [2:0] CLS_AUIPC = 3'd6;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;

  // Registered state
  logic            valid_reg;
  logic [XLEN-1:0] a_reg, b_reg, store_data_reg;
  logic [3:0]      opcode_reg;
  logic [4:0]      rd_reg;
  logic            reg_write_reg;
  logic [2:0]      class_reg, funct3_reg;

  // Next-state values for a captured instruction
  logic [XLEN-1:0] a_next, b_next;
  logic [3:0]      opcode_next;

  // Per-source forwarding: index 0 is rs1, index 1 is rs2
  logic [4:0]      rs_idx  [2];
  logic [XLEN-1:0] rf_data [2];
  logic [XLEN-1:0] fwd     [2];
  logic            rs_used [2];

  assign rs_idx[0]  = id_rs1;
  assign rs_idx[1]  = id_rs2;
  assign rf_data[0] = id_rs1_data;
  assign rf_data[1] = id_rs2_data;
  assign rs_used[0] = (id_class != CLS_LUI) && (id_class != CLS_AUIPC);
  assign rs_used[1] = (id_class == CLS_R) || (id_class == CLS_BR) ||
                      (id_class == CLS_STORE);

  // A load in EX has no data yet, so it is never an EX forward source;
  // that case is covered by the hazard stall instead.
  logic ex_fwd_ok;
  assign ex_fwd_ok = valid_reg && reg_write_reg && (class_reg != CLS_LOAD) &&
                     (rd_reg != 5'd0);

  logic [1:0] load_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      always_comb begin
        fwd[gi] = rf_data[gi];
        if (ex_fwd_ok && (rd_reg == rs_idx[gi])) begin
          fwd[gi] = ex_alu_result;
        end else if (exmem_reg_write && (exmem_rd != 5'd0) &&
                     (exmem_rd == rs_idx[gi])) begin
          fwd[gi] = exmem_result;
        end
      end
      assign load_hit[gi] = rs_used[gi] && (rs_idx[gi] == rd_reg);
    end
  endgenerate

  assign hazard_stall = !flush && id_valid && valid_reg &&
                        (class_reg == CLS_LOAD) && (rd_reg != 5'd0) &&
                        (|load_hit);

  // Opcode mapping
  always_comb begin
    opcode_next = OP_ADD;
    case (id_class)
      CLS_R: opcode_next = {id_funct7_5, id_funct3};
      CLS_I: begin
        // Only the shift-right immediate carries funct7_5 into the opcode
        if (id_funct3 == 3'b101) opcode_next = {id_funct7_5, 3'b101};
        else                     opcode_next = {1'b0, id_funct3};
      end
      CLS_BR: begin
        case (id_funct3[2:1])
          2'b10:   opcode_next = OP_SLT;
          2'b11:   opcode_next = OP_SLTU;
          default: opcode_next = OP_SUB;
        endcase
      end
      default: opcode_next = OP_ADD;
    endcase
  end

  // Operand selection
  always_comb begin
    a_next = fwd[0];
    if (id_class == CLS_LUI)   a_next = '0;
    if (id_class == CLS_AUIPC) a_next = id_pc;
    b_next = id_imm;
    if ((id_class == CLS_R) || (id_class == CLS_BR) || (id_class == 3'd7)) begin
      b_next = fwd[1];
    end
  end

  logic bubble;
  assign bubble = flush || hazard_stall || !id_valid;

  always_ff @(posedge clk) begin
    if (reset || (!stall && bubble)) begin
      valid_reg      <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      opcode_reg     <= OP_ADD;
      store_data_reg <= '0;
      rd_reg         <= 5'd0;
      reg_write_reg  <= 1'b0;
      class_reg      <= 3'd0;
      funct3_reg     <= 3'd0;
    end else if (!stall) begin
      valid_reg      <= 1'b1;
      a_reg          <= a_next;
      b_reg          <= b_next;
      opcode_reg     <= opcode_next;
      store_data_reg <= fwd[1];
      rd_reg         <= id_rd;
      reg_write_reg  <= id_reg_write;
      class_reg      <= id_class;
      funct3_reg     <= id_funct3;
    end
  end

  assign ex_valid      = valid_reg;
  assign ex_a          = a_reg;
  assign ex_b          = b_reg;
  assign ex_opcode     = opcode_reg;
  assign ex_store_data = store_data_reg;
  assign ex_rd         = rd_reg;
  assign ex_reg_write  = reg_write_reg;
  assign ex_class      = class_reg;
  assign ex_funct3     = funct3_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: each stimulus cycle pushes the expected
// registered outputs; a monitor pops and compares one entry after every edge.
module tb_id_ex_stage;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset, id_valid, id_funct7_5, id_reg_write;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd, exmem_rd;
  logic [2:0]      id_class, id_funct3;
  logic [XLEN-1:0] ex_alu_result, exmem_result;
  logic            exmem_reg_write, stall, flush;
  logic            hazard_stall, ex_valid, ex_reg_write;
  logic [XLEN-1:0] ex_a, ex_b, ex_store_data;
  logic [3:0]      ex_opcode;
  logic [4:0]      ex_rd;
  logic [2:0]      ex_class, ex_funct3;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_class(id_class),
    .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .id_reg_write(id_reg_write), .ex_alu_result(ex_alu_result),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .exmem_result(exmem_result), .stall(stall), .flush(flush),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_a(ex_a),
    .ex_b(ex_b), .ex_opcode(ex_opcode), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_class(ex_class),
    .ex_funct3(ex_funct3)
  );

  typedef struct {
    string           name;
    logic            v;
    logic [XLEN-1:0] a, b, sd;
    logic [3:0]      op;
    logic [4:0]      rd;
    logic            rw;
    logic [2:0]      cls, f3;
  } exp_t;

  exp_t sb[$];

  task automatic push(input string name, input logic v, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [3:0] op,
                      input logic [XLEN-1:0] sd, input logic [4:0] rd,
                      input logic rw, input logic [2:0] cls, input logic [2:0] f3);
    exp_t e;
    e.name = name; e.v = v; e.a = a; e.b = b; e.op = op; e.sd = sd;
    e.rd = rd; e.rw = rw; e.cls = cls; e.f3 = f3;
    sb.push_back(e);
  endtask

  task automatic bubble_exp(input string name);
    push(name, 1'b0, '0, '0, 4'b0000, '0, 5'd0, 1'b0, 3'd0, 3'd0);
  endtask

  task automatic instr(input logic [2:0] cls, input logic [2:0] f3, input logic f75,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                       input logic [XLEN-1:0] imm, input logic rw);
    id_valid = 1'b1; id_class = cls; id_funct3 = f3; id_funct7_5 = f75;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1;
    id_rs2_data = d2; id_imm = imm; id_reg_write = rw;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_hz(input string name, input logic req);
    #1;
    checks++;
    if (hazard_stall !== req) begin
      errors++;
      $display("FAIL %s: hazard_stall got %b expected %b", name, hazard_stall, req);
    end else begin
      $display("ok   %s: hazard_stall=%b", name, hazard_stall);
    end
  endtask

  // Monitor: one expected entry per edge in which stimulus pushed one
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        txn++;
        if (ex_valid !== e.v || ex_a !== e.a || ex_b !== e.b || ex_opcode !== e.op ||
            ex_store_data !== e.sd || ex_rd !== e.rd || ex_reg_write !== e.rw ||
            ex_class !== e.cls || ex_funct3 !== e.f3) begin
          errors++;
          $display("FAIL %s: got v=%b a=%h b=%h op=%b sd=%h rd=%0d rw=%b cls=%0d f3=%0d expected v=%b a=%h b=%h op=%b sd=%h rd=%0d rw=%b cls=%0d f3=%0d",
                   e.name, ex_valid, ex_a, ex_b, ex_opcode, ex_store_data, ex_rd,
                   ex_reg_write, ex_class, ex_funct3, e.v, e.a, e.b, e.op, e.sd,
                   e.rd, e.rw, e.cls, e.f3);
        end else begin
          $display("ok   txn %0d %s: v=%b a=%h b=%h op=%b", txn, e.name,
                   ex_valid, ex_a, ex_b, ex_opcode);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; id_pc = '0;
    ex_alu_result = '0; exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_result = '0;
    instr(3'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 64'h5, 64'h3, 64'h0, 1'b1);
    bubble_exp("reset");
    step();
    reset = 1'b0;

    // R-ALU SUB
    instr(3'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 64'h5, 64'h3, 64'h0, 1'b1);
    push("r_sub", 1, 64'h5, 64'h3, 4'b1000, 64'h3, 5'd3, 1, 3'd0, 3'd0);
    step();
    // SRAI
    instr(3'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd4, 64'h80, 64'h3, 64'h401, 1'b1);
    push("srai", 1, 64'h80, 64'h401, 4'b1101, 64'h3, 5'd4, 1, 3'd1, 3'd5);
    step();
    // ADDI with f7_5 set must still be ADD
    instr(3'd1, 3'd0, 1'b1, 5'd1, 5'd2, 5'd6, 64'h80, 64'h3, 64'h7, 1'b1);
    push("addi_f7", 1, 64'h80, 64'h7, 4'b0000, 64'h3, 5'd6, 1, 3'd1, 3'd0);
    step();
    // ADD rd=5 enters EX
    instr(3'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd5, 64'h80, 64'h3, 64'h0, 1'b1);
    push("add_rd5", 1, 64'h80, 64'h3, 4'b0000, 64'h3, 5'd5, 1, 3'd0, 3'd0);
    step();
    // EX forward beats EX/MEM
    ex_alu_result = 64'h1234; exmem_rd = 5'd5; exmem_reg_write = 1'b1; exmem_result = 64'hDEAD;
    instr(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd8, 64'h80, 64'h3, 64'h0, 1'b1);
    push("fwd_ex", 1, 64'h1234, 64'h3, 4'b0000, 64'h3, 5'd8, 1, 3'd0, 3'd0);
    step();
    // Invalid ID -> bubble
    id_valid = 1'b0;
    bubble_exp("idle_bubble");
    step();
    // EX bubbled -> EX/MEM forward; rd=0 write to set up the x0 case
    instr(3'd0, 3'd0, 1'b0, 5'd5, 5'd2, 5'd0, 64'h80, 64'h3, 64'h0, 1'b1);
    push("fwd_exmem", 1, 64'hDEAD, 64'h3, 4'b0000, 64'h3, 5'd0, 1, 3'd0, 3'd0);
    step();
    // x0 on both sources never forwarded
    exmem_rd = 5'd0;
    instr(3'd0, 3'd0, 1'b0, 5'd0, 5'd2, 5'd10, 64'h55, 64'h3, 64'h0, 1'b1);
    push("x0_nofwd", 1, 64'h55, 64'h3, 4'b0000, 64'h3, 5'd10, 1, 3'd0, 3'd0);
    step();
    // LOAD rd=7 into EX
    exmem_reg_write = 1'b0;
    instr(3'd2, 3'd3, 1'b0, 5'd1, 5'd2, 5'd7, 64'h100, 64'h3, 64'h8, 1'b1);
    push("load", 1, 64'h100, 64'h8, 4'b0000, 64'h3, 5'd7, 1, 3'd2, 3'd3);
    step();
    // Dependent R-ALU: hazard -> bubble
    ex_alu_result = 64'hBAD;
    instr(3'd0, 3'd0, 1'b0, 5'd1, 5'd7, 5'd11, 64'h100, 64'h3, 64'h0, 1'b1);
    check_hz("loaduse_hz", 1'b1);
    bubble_exp("loaduse_bubble");
    step();
    // Load data now from EX/MEM
    exmem_rd = 5'd7; exmem_reg_write = 1'b1; exmem_result = 64'hCAFE;
    check_hz("loaduse_clear", 1'b0);
    push("loaduse_fwd", 1, 64'h100, 64'hCAFE, 4'b0000, 64'hCAFE, 5'd11, 1, 3'd0, 3'd0);
    step();
    // stall + flush for 3 cycles: hold
    exmem_reg_write = 1'b0;
    stall = 1'b1; flush = 1'b1;
    instr(3'd1, 3'd0, 1'b0, 5'd1, 5'd2, 5'd13, 64'h1, 64'h2, 64'h3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      push("stall_hold", 1, 64'h100, 64'hCAFE, 4'b0000, 64'hCAFE, 5'd11, 1, 3'd0, 3'd0);
      step();
    end
    stall = 1'b0;
    bubble_exp("flush");
    step();
    flush = 1'b0;
    // BGEU
    instr(3'd4, 3'd7, 1'b0, 5'd1, 5'd2, 5'd0, 64'h10, 64'h20, 64'h40, 1'b0);
    push("bgeu", 1, 64'h10, 64'h20, 4'b0011, 64'h20, 5'd0, 0, 3'd4, 3'd7);
    step();
    // LUI
    instr(3'd5, 3'd0, 1'b0, 5'd1, 5'd2, 5'd12, 64'h99, 64'h20, 64'h5000, 1'b1);
    push("lui", 1, 64'h0, 64'h5000, 4'b0000, 64'h20, 5'd12, 1, 3'd5, 3'd0);
    step();
    // AUIPC
    id_pc = 64'h400;
    instr(3'd6, 3'd0, 1'b0, 5'd1, 5'd2, 5'd14, 64'h99, 64'h20, 64'h10, 1'b1);
    push("auipc", 1, 64'h400, 64'h10, 4'b0000, 64'h20, 5'd14, 1, 3'd6, 3'd0);
    step();
    // Reset during stall clears everything
    stall = 1'b1; reset = 1'b1;
    bubble_exp("reset_in_stall");
    step();
    stall = 1'b0; reset = 1'b0; id_valid = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
